// File: rtl/rstctl01_pkg.sv
// Shared types for the rstctl01 reset sequencer: FSM state encoding and
// reset-cause codes reported on the cause output.
package rstctl01_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ASSERT  = 2'b01,
        S_RELEASE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } cause_t;

endpackage

// File: rtl/rstctl01_if.sv
// Request/status bundle between the reset sequencer (slave) and the system
// side that drives requests and returns per-domain reset status (master).
interface rstctl01_if
    import rstctl01_pkg::*;
#(
    parameter int NDOM = 2
);
    logic            swreq;
    logic            wdt_en;
    logic            wdt_kick;
    logic [NDOM-1:0] rstmsk;
    logic [NDOM-1:0] dom_rst_;
    logic            clr_err;
    logic            orst_;
    logic            busy;
    logic            done;
    logic            tout_err;
    cause_t          cause;

    modport master (
        output swreq, wdt_en, wdt_kick, rstmsk, dom_rst_, clr_err,
        input  orst_, busy, done, tout_err, cause
    );

    modport slave (
        input  swreq, wdt_en, wdt_kick, rstmsk, dom_rst_, clr_err,
        output orst_, busy, done, tout_err, cause
    );
endinterface

// File: rtl/rstctl01_wdt.sv
// rstwdt01: free-running watchdog counter that counts only while the
// sequencer is idle and raises expire when it reaches all ones.
module rstwdt01 #(
    parameter int WDTW = 16
) (
    input  logic clk,
    input  logic rst_,
    input  logic run,
    input  logic en,
    input  logic kick,
    input  logic clear,
    output logic expire
);
    logic [WDTW-1:0] cnt_q;
    logic [WDTW-1:0] cnt_d;

    // Next count: kick, disable or sequence start zero it; otherwise count while idle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || kick || !en) begin
            cnt_d = {WDTW{1'b0}};
        end else if (run && (cnt_q != {WDTW{1'b1}})) begin
            cnt_d = cnt_q + WDTW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            cnt_q <= {WDTW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = run && en && !kick && (cnt_q == {WDTW{1'b1}});

endmodule

// File: rtl/rstctl01.sv
// rstctl01: global reset request sequencer with minimum-width hold, per-domain
// entry/exit acknowledge, timeout flag and cause log. Watchdog source is built
// only when RSTCTL_WDT_EN is defined.
module rstctl01
    import rstctl01_pkg::*;
#(
    parameter int NDOM = 2,
    parameter int MINW = 16,
    parameter int TOUT = 255,
    parameter int WDTW = 16
) (
    input logic       clk,
    input logic       rst_,
    rstctl01_if.slave bus
);
    localparam int WCW = (MINW > 2) ? $clog2(MINW) : 1;
    localparam int TCW = $clog2(TOUT + 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           orst_q, orst_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tout_err_q, tout_err_d;
    cause_t         cause_q, cause_d;

    logic           set_err_s;
    logic           ack_lo_s;
    logic           ack_hi_s;
    logic           wdt_exp_s;
    logic           wdt_start_s;

    // Masked domains always read as acknowledged, in either direction.
    assign ack_lo_s = &(~bus.dom_rst_ | bus.rstmsk);
    assign ack_hi_s = &( bus.dom_rst_ | bus.rstmsk);

`ifdef RSTCTL_WDT_EN
    logic wdt_run_s;
    assign wdt_run_s = (state_q == S_IDLE);

    rstwdt01 #(.WDTW(WDTW)) u_wdt (
        .clk    (clk),
        .rst_   (rst_),
        .run    (wdt_run_s),
        .en     (bus.wdt_en),
        .kick   (bus.wdt_kick),
        .clear  (wdt_start_s),
        .expire (wdt_exp_s)
    );
`else
    logic unused_wdt_s;
    assign wdt_exp_s    = 1'b0;
    assign unused_wdt_s = &{1'b0, bus.wdt_en, bus.wdt_kick, wdt_start_s, WDTW[0]};
`endif

    // Sequencer next state, counters and cause.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        cause_d     = cause_q;
        done_d      = 1'b0;
        set_err_s   = 1'b0;
        wdt_start_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wdt_exp_s || bus.swreq) begin
                    state_d     = S_ASSERT;
                    wcnt_d      = WCW'(MINW - 1);
                    tcnt_d      = {TCW{1'b0}};
                    wdt_start_s = 1'b1;
                    cause_d     = wdt_exp_s ? CAUSE_WDT : CAUSE_SW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ASSERT: begin
                // Acknowledges are only honoured once the minimum width has elapsed.
                if (wcnt_q != {WCW{1'b0}}) begin
                    wcnt_d = wcnt_q - WCW'(1);
                end else if (ack_lo_s) begin
                    state_d = S_RELEASE;
                    tcnt_d  = {TCW{1'b0}};
                end else if (tcnt_q == TCW'(TOUT)) begin
                    set_err_s = 1'b1;
                    state_d   = S_RELEASE;
                    tcnt_d    = {TCW{1'b0}};
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            S_RELEASE: begin
                if (ack_hi_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tcnt_q == TCW'(TOUT)) begin
                    set_err_s = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            default: begin
                state_d = S_ASSERT;
                wcnt_d  = WCW'(MINW - 1);
                tcnt_d  = {TCW{1'b0}};
            end
        endcase

        orst_d = (state_d != S_ASSERT);
        busy_d = (state_d != S_IDLE);

        if (set_err_s) begin
            tout_err_d = 1'b1;
        end else if (bus.clr_err) begin
            tout_err_d = 1'b0;
        end else begin
            tout_err_d = tout_err_q;
        end
    end

    // State and output registers; reset puts the sequencer straight into ASSERT.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= S_ASSERT;
            wcnt_q     <= WCW'(MINW - 1);
            tcnt_q     <= {TCW{1'b0}};
            orst_q     <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            tout_err_q <= 1'b0;
            cause_q    <= CAUSE_POR;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            orst_q     <= orst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tout_err_q <= tout_err_d;
            cause_q    <= cause_d;
        end
    end

    assign bus.orst_    = orst_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tout_err = tout_err_q;
    assign bus.cause    = cause_q;

endmodule

// File: tb/tb_rstctl01.sv
// Directed bench for rstctl01: POR, software request, timeout, masking,
// mid-sequence reset, error clear and the watchdog (RSTCTL_WDT_EN on or off).
module tb_rstctl01;
    import rstctl01_pkg::*;

    localparam int NDOM = 2;
    localparam int MINW = 16;
    localparam int TOUT = 255;
    localparam int WDTW = 4;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    rstctl01_if #(.NDOM(NDOM)) bus ();

    rstctl01 #(.NDOM(NDOM), .MINW(MINW), .TOUT(TOUT), .WDTW(WDTW)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int              n_checks = 0;
    int              n_errors = 0;
    logic [2:0]      lag      = 3'b000;
    logic [NDOM-1:0] stuck    = '0;

    // Advance to the next falling edge; domains echo orst_ with a short lag.
    task automatic tick();
        @(negedge clk);
        lag = {lag[1:0], bus.orst_};
        for (int d = 0; d < NDOM; d++) bus.dom_rst_[d] = stuck[d] ? 1'b1 : lag[2];
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        bus.swreq = 1'b0; bus.wdt_en = 1'b0; bus.wdt_kick = 1'b0;
        bus.rstmsk = '0; bus.dom_rst_ = '0; bus.clr_err = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus.orst_ !== 1'b0) begin n_errors++; $display("FAIL rst_orst: got %b expected 0", bus.orst_); end
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL rst_busy: got %b expected 1", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.tout_err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", bus.tout_err); end
        n_checks++; if (bus.cause !== CAUSE_POR) begin n_errors++; $display("FAIL rst_cause: got %b expected 00", bus.cause); end
    endtask

    task automatic test_por();
        int low = 5;
        int ndone = 0;
        rst_ = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.orst_ === 1'b0) low++;
            if (bus.done === 1'b1) ndone++;
        end
        n_checks++; if (low !== 20) begin n_errors++; $display("FAIL por_width: got %0d expected 20", low); end
        n_checks++; if (ndone !== 1) begin n_errors++; $display("FAIL por_done: got %0d expected 1", ndone); end
        n_checks++; if (bus.cause !== CAUSE_POR) begin n_errors++; $display("FAIL por_cause: got %b expected 00", bus.cause); end
        n_checks++; if (bus.tout_err !== 1'b0) begin n_errors++; $display("FAIL por_err: got %b expected 0", bus.tout_err); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL por_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_swreq();
        int low = 1;
        int ndone = 0;
        int dsamp = -1;
        bus.swreq = 1'b1; tick(); bus.swreq = 1'b0;
        n_checks++; if (bus.orst_ !== 1'b0) begin n_errors++; $display("FAIL sw_orst: got %b expected 0", bus.orst_); end
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL sw_busy: got %b expected 1", bus.busy); end
        n_checks++; if (bus.cause !== CAUSE_SW) begin n_errors++; $display("FAIL sw_cause: got %b expected 01", bus.cause); end
        for (int k = 1; k <= 40; k++) begin
            bus.swreq = (k == 5);
            tick();
            if (bus.orst_ === 1'b0) low++;
            if (bus.done === 1'b1) begin ndone++; dsamp = k; end
        end
        bus.swreq = 1'b0;
        n_checks++; if (low !== 16) begin n_errors++; $display("FAIL sw_width: got %0d expected 16", low); end
        n_checks++; if (ndone !== 1) begin n_errors++; $display("FAIL sw_ndone: got %0d expected 1", ndone); end
        n_checks++; if (dsamp !== 19) begin n_errors++; $display("FAIL sw_done_cycle: got %0d expected 19", dsamp); end
        n_checks++; if (bus.cause !== CAUSE_SW) begin n_errors++; $display("FAIL sw_cause_end: got %b expected 01", bus.cause); end
    endtask

    task automatic test_timeout();
        int hit = -1;
        int found = 0;
        stuck = 2'b10; bus.rstmsk = 2'b00; tick();
        bus.swreq = 1'b1; tick(); bus.swreq = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            bus.clr_err = (k == 271);
            tick();
            if (bus.tout_err === 1'b1) begin hit = k; break; end
        end
        bus.clr_err = 1'b0;
        n_checks++; if (hit !== 271) begin n_errors++; $display("FAIL tout_cycle: got %0d expected 271", hit); end
        n_checks++; if (bus.orst_ !== 1'b1) begin n_errors++; $display("FAIL tout_release: got %b expected 1", bus.orst_); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.done === 1'b1) begin found = 1; break; end
        end
        n_checks++; if (found !== 1) begin n_errors++; $display("FAIL tout_done: got %0d expected 1", found); end
        n_checks++; if (bus.tout_err !== 1'b1) begin n_errors++; $display("FAIL tout_sticky: got %b expected 1", bus.tout_err); end
    endtask

    task automatic test_mask();
        int dsamp = -1;
        bus.rstmsk = 2'b10; tick(); tick();
        bus.swreq = 1'b1; tick(); bus.swreq = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.done === 1'b1) begin dsamp = k; break; end
        end
        n_checks++; if (dsamp !== 19) begin n_errors++; $display("FAIL mask_done_cycle: got %0d expected 19", dsamp); end
        n_checks++; if (bus.tout_err !== 1'b1) begin n_errors++; $display("FAIL mask_err: got %b expected 1", bus.tout_err); end
    endtask

    task automatic test_midreset();
        int found = 0;
        stuck = 2'b00; bus.rstmsk = 2'b00; tick(); tick();
        bus.swreq = 1'b1; tick(); bus.swreq = 1'b0;
        for (int k = 1; k <= 16; k++) tick();
        n_checks++; if ({bus.orst_, bus.busy} !== 2'b11) begin n_errors++; $display("FAIL mid_release: got %b expected 11", {bus.orst_, bus.busy}); end
        rst_ = 1'b0; tick();
        n_checks++; if (bus.orst_ !== 1'b0) begin n_errors++; $display("FAIL mid_orst: got %b expected 0", bus.orst_); end
        n_checks++; if (bus.tout_err !== 1'b0) begin n_errors++; $display("FAIL mid_err: got %b expected 0", bus.tout_err); end
        n_checks++; if (bus.cause !== CAUSE_POR) begin n_errors++; $display("FAIL mid_cause: got %b expected 00", bus.cause); end
        rst_ = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.done === 1'b1) begin found = 1; break; end
        end
        n_checks++; if (found !== 1) begin n_errors++; $display("FAIL mid_por_done: got %0d expected 1", found); end
    endtask

    task automatic test_clr();
        int found = 0;
        stuck = 2'b01; tick();
        bus.swreq = 1'b1; tick(); bus.swreq = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (bus.done === 1'b1) begin found = 1; break; end
        end
        n_checks++; if ({found[0], bus.tout_err} !== 2'b11) begin n_errors++; $display("FAIL clr_setup: got %b expected 11", {found[0], bus.tout_err}); end
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        n_checks++; if (bus.tout_err !== 1'b0) begin n_errors++; $display("FAIL clr_err: got %b expected 0", bus.tout_err); end
        tick();
        n_checks++; if (bus.tout_err !== 1'b0) begin n_errors++; $display("FAIL clr_hold: got %b expected 0", bus.tout_err); end
        stuck = 2'b00; tick(); tick();
    endtask

`ifdef RSTCTL_WDT_EN
    task automatic test_wdt();
        int first = -1;
        int found = 0;
        int low = 0;
        bus.wdt_en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.orst_ === 1'b0) begin first = k; break; end
        end
        n_checks++; if (first !== 16) begin n_errors++; $display("FAIL wdt_cycle: got %0d expected 16", first); end
        n_checks++; if (bus.cause !== CAUSE_WDT) begin n_errors++; $display("FAIL wdt_cause: got %b expected 10", bus.cause); end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.done === 1'b1) begin found = 1; break; end
        end
        first = -1;
        for (int j = 1; j <= 30; j++) begin
            bus.swreq = (j == 16);
            tick();
            if (bus.orst_ === 1'b0) begin first = j; break; end
        end
        bus.swreq = 1'b0;
        n_checks++; if (first !== 16) begin n_errors++; $display("FAIL wdt_both_cycle: got %0d expected 16", first); end
        n_checks++; if (bus.cause !== CAUSE_WDT) begin n_errors++; $display("FAIL wdt_both_cause: got %b expected 10", bus.cause); end
        bus.wdt_en = 1'b0;
        for (int k = 1; k <= 40; k++) tick();
        bus.wdt_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            bus.wdt_kick = (k % 8 == 0);
            tick();
            if (bus.orst_ === 1'b0) low++;
        end
        bus.wdt_kick = 1'b0; bus.wdt_en = 1'b0;
        n_checks++; if (low !== 0) begin n_errors++; $display("FAIL wdt_kick: got %0d expected 0", low); end
    endtask
`else
    task automatic test_wdt();
        int low = 0;
        bus.wdt_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus.orst_ === 1'b0 || bus.busy === 1'b1) low++;
        end
        bus.wdt_en = 1'b0;
        n_checks++; if (low !== 0) begin n_errors++; $display("FAIL wdt_off: got %0d expected 0", low); end
        n_checks++; if (bus.cause === CAUSE_WDT) begin n_errors++; $display("FAIL wdt_off_cause: got %b expected not 10", bus.cause); end
    endtask
`endif

    initial begin
        test_reset();
        test_por();
        test_swreq();
        test_timeout();
        test_mask();
        test_midreset();
        test_clr();
        test_wdt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
